bit_unstuffer: RTL and testbench

- Receive-path stage between the NRZI decoder and the PID/CRC decode stage.
- Hunts for the SYNC pattern in the decoded serial bitstream, then strips stuffed zeros after STUFF_LIMIT consecutive ones.
- Forwards payload bits one at a time, with frame start and end pulses, to the downstream decoder.
- Flags bit-stuff violations and non-byte-aligned packets at EOP.

---
 rtl/bit_unstuffer.sv | 174 +++++++++++++++++
 tb/tb_bit_unstuffer.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit_unstuffer.sv
// Receive-path bit unstuffer: hunts SYNC, strips stuffed zeros,
// and forwards payload bits with frame start/end pulses.
module bit_unstuffer #(
  parameter logic [7:0] SYNC_PATTERN = 8'b0000_0001,
  parameter int         STUFF_LIMIT  = 6,
  parameter int         CNT_W        = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic abort,
  input  logic bit_en,
  input  logic d_in,
  input  logic se0,
  output logic s_out,
  output logic s_valid,
  output logic start_decode,
  output logic end_decode,
  output logic stuff_error,
  output logic align_error,
  output logic rx_active
);

  localparam int OW = $clog2(STUFF_LIMIT + 1);
  localparam logic [OW-1:0] LIMIT = OW'(STUFF_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    ERROR,
    EOP
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [OW-1:0]    ones_cnt_q, ones_cnt_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic             first_q, first_d;
  logic             s_out_q, s_out_d;
  logic             s_valid_q, s_valid_d;
  logic             start_q, start_d;
  logic             end_q, end_d;
  logic             stuff_err_q, stuff_err_d;
  logic             align_q, align_d;
  logic             rx_active_q, rx_active_d;
  logic [7:0]       shifted;

  assign shifted = {shreg_q[6:0], d_in};

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    ones_cnt_d  = ones_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    first_d     = first_q;
    s_out_d     = s_out_q;
    s_valid_d   = 1'b0;
    start_d     = 1'b0;
    end_d       = 1'b0;
    align_d     = 1'b0;
    stuff_err_d = stuff_err_q;
    rx_active_d = rx_active_q;
    if (abort) begin
      state_d     = IDLE;
      shreg_d     = '0;
      ones_cnt_d  = '0;
      bit_cnt_d   = '0;
      first_d     = 1'b0;
      s_out_d     = 1'b0;
      stuff_err_d = 1'b0;
      rx_active_d = 1'b0;
    end else if (bit_en) begin
      unique case (state_q)
        IDLE: begin
          if (se0) begin
            shreg_d = '0;
          end else begin
            shreg_d = shifted;
            if (shifted == SYNC_PATTERN) begin
              // The closing SYNC one counts toward the stuffing run
              state_d     = RECV;
              ones_cnt_d  = OW'(1);
              bit_cnt_d   = '0;
              first_d     = 1'b1;
              rx_active_d = 1'b1;
            end
          end
        end
        RECV: begin
          if (se0) begin
            if (first_q) begin
              state_d     = IDLE;
              shreg_d     = '0;
              first_d     = 1'b0;
              rx_active_d = 1'b0;
            end else begin
              state_d = EOP;
              end_d   = 1'b1;
              align_d = (bit_cnt_q[2:0] != 3'd0);
            end
          end else if (ones_cnt_q == LIMIT) begin
            if (d_in) begin
              state_d     = ERROR;
              stuff_err_d = 1'b1;
            end else begin
              ones_cnt_d = '0;
            end
          end else begin
            s_out_d   = d_in;
            s_valid_d = 1'b1;
            start_d   = first_q;
            first_d   = 1'b0;
            if (bit_cnt_q != '1) begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
            ones_cnt_d = d_in ? ones_cnt_q + 1'b1 : '0;
          end
        end
        ERROR: begin
          if (se0) begin
            state_d = EOP;
          end
        end
        EOP: begin
          if (!se0) begin
            state_d     = IDLE;
            shreg_d     = '0;
            stuff_err_d = 1'b0;
            rx_active_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      ones_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      first_q     <= 1'b0;
      s_out_q     <= 1'b0;
      s_valid_q   <= 1'b0;
      start_q     <= 1'b0;
      end_q       <= 1'b0;
      stuff_err_q <= 1'b0;
      align_q     <= 1'b0;
      rx_active_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      ones_cnt_q  <= ones_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      first_q     <= first_d;
      s_out_q     <= s_out_d;
      s_valid_q   <= s_valid_d;
      start_q     <= start_d;
      end_q       <= end_d;
      stuff_err_q <= stuff_err_d;
      align_q     <= align_d;
      rx_active_q <= rx_active_d;
    end
  end

  assign s_out        = s_out_q;
  assign s_valid      = s_valid_q;
  assign start_decode = start_q;
  assign end_decode   = end_q;
  assign stuff_error  = stuff_err_q;
  assign align_error  = align_q;
  assign rx_active    = rx_active_q;

endmodule

// File: tb/tb_bit_unstuffer.sv
// Randomized self-checking bench for bit_unstuffer against a
// behavioural packet model.
module tb_bit_unstuffer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;
  logic bit_en = 1'b0;
  logic d_in = 1'b0;
  logic se0 = 1'b0;
  logic s_out, s_valid, start_decode, end_decode;
  logic stuff_error, align_error, rx_active;

  int n_checks = 0;
  int n_fail = 0;

  localparam logic [7:0] SYNC = 8'b0000_0001;
  localparam int SE0 = 2;

  bit_unstuffer dut (
    .clk(clk),
    .rst_n(rst_n),
    .abort(abort),
    .bit_en(bit_en),
    .d_in(d_in),
    .se0(se0),
    .s_out(s_out),
    .s_valid(s_valid),
    .start_decode(start_decode),
    .end_decode(end_decode),
    .stuff_error(stuff_error),
    .align_error(align_error),
    .rx_active(rx_active)
  );

  always #5 clk = ~clk;

  // Model state: 0 hunting, 1 payload, 2 violated, 3 end of packet
  int m_mode, m_win, m_run, m_npay;
  bit m_rx, m_stf;

  function automatic void m_reset();
    m_mode = 0; m_win = 0; m_run = 0; m_npay = 0;
    m_rx = 0; m_stf = 0;
  endfunction

  // vector: rx, stuff, align, end, start, valid, data&valid
  function automatic logic [6:0] m_step(int sym, bit ab);
    bit d, z, v, st, en, al, so;
    d = (sym == 1); z = (sym == SE0);
    v = 0; st = 0; en = 0; al = 0; so = 0;
    if (ab) begin
      m_reset();
      return 7'd0;
    end
    case (m_mode)
      0: begin
        if (z) m_win = 0;
        else m_win = ((m_win << 1) | int'(d)) & 255;
        if (!z && m_win == int'(SYNC)) begin
          m_mode = 1; m_run = 1; m_npay = 0; m_rx = 1;
        end
      end
      1: begin
        if (z) begin
          if (m_npay == 0) begin
            m_mode = 0; m_rx = 0; m_win = 0;
          end else begin
            en = 1; al = ((m_npay < 2047 ? m_npay : 2047) % 8) != 0;
            m_mode = 3;
          end
        end else if (m_run == 6) begin
          if (d) begin m_stf = 1; m_mode = 2; end
          else m_run = 0;
        end else begin
          v = 1; so = d; st = (m_npay == 0);
          m_npay++;
          m_run = d ? m_run + 1 : 0;
        end
      end
      2: if (z) m_mode = 3;
      default: if (!z) begin
        m_mode = 0; m_rx = 0; m_stf = 0; m_win = 0;
      end
    endcase
    return {m_rx, m_stf, al, en, st, v, so};
  endfunction

  function automatic logic [6:0] outv();
    return {rx_active, stuff_error, align_error, end_decode,
            start_decode, s_valid, s_out & s_valid};
  endfunction

  // Drive one bit_en cycle, sample its response, then idle gap cycles
  task automatic send(input int sym, input bit ab, input int gap,
                      output logic [6:0] obs, output logic [6:0] idl);
    bit_en = 1'b1;
    d_in = (sym == 1);
    se0 = (sym == SE0);
    abort = ab;
    @(posedge clk); #1;
    bit_en = 1'b0; d_in = 1'b0; se0 = 1'b0; abort = 1'b0;
    obs = outv();
    idl = obs;
    if (gap > 0) begin
      @(posedge clk); #1;
      idl = outv();
      repeat (gap - 1) @(posedge clk);
      if (gap > 1) #1;
    end
  endtask

  function automatic void push_sync(inout int q[$]);
    for (int i = 7; i >= 0; i--) q.push_back(int'(SYNC[i]));
  endfunction

  function automatic void push_a5(inout int q[$]);
    logic [7:0] b;
    b = 8'hA5;
    for (int i = 0; i < 8; i++) q.push_back(int'(b[i]));
  endfunction

  task automatic test_reset();
    bit_en = 1'b1; d_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({rx_active, stuff_error, align_error, end_decode, start_decode,
         s_valid, s_out} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_hold got %b want 0", outv());
    end
    bit_en = 1'b0; d_in = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if ({rx_active, stuff_error, align_error, end_decode, start_decode,
         s_valid, s_out} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_release got %b want 0", outv());
    end
    m_reset();
  endtask

  task automatic test_basic(input int gap);
    int q[$];
    logic [6:0] o, i, e;
    logic [7:0] byt;
    int nv, ne, na, ns;
    nv = 0; ne = 0; na = 0; ns = 0; byt = '0;
    push_sync(q); push_a5(q);
    q.push_back(SE0); q.push_back(SE0); q.push_back(0);
    foreach (q[k]) begin
      e = m_step(q[k], 0);
      send(q[k], 0, gap, o, i);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL basic step %0d got %b want %b", k, o, e);
      end
      if (gap > 0) begin
        n_checks++;
        if (i !== {e[6:5], 5'd0}) begin
          n_fail++;
          $display("FAIL basic_idle step %0d got %b want %b", k, i,
                   {e[6:5], 5'd0});
        end
      end
      if (o[1] && nv < 8) byt[nv] = o[0];
      nv += int'(o[1]); ne += int'(o[3]);
      na += int'(o[4]); ns += int'(o[5]);
    end
    n_checks++;
    if (nv != 8 || byt !== 8'hA5 || ne != 1 || na != 0 || ns != 0
        || o[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_summary got nv=%0d byte=%h ne=%0d na=%0d ns=%0d rx=%b want 8 a5 1 0 0 0",
               nv, byt, ne, na, ns, o[6]);
    end
  endtask

  task automatic test_stuff();
    int q[$];
    int want[$];
    int got[$];
    logic [6:0] o, i, e;
    int na, ne;
    want = '{1,1,1,1,1,1,1,0,0,1,1,1};
    na = 0; ne = 0;
    push_sync(q);
    q = {q, 1,1,1,1,1,0,1,1,0,0,1,1,1, SE0, 0};
    foreach (q[k]) begin
      e = m_step(q[k], 0);
      send(q[k], 0, 2, o, i);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL stuff step %0d got %b want %b", k, o, e);
      end
      if (o[1]) got.push_back(int'(o[0]));
      na += int'(o[4]); ne += int'(o[3]);
    end
    n_checks++;
    if (got != want || na != 1 || ne != 1) begin
      n_fail++;
      $display("FAIL stuff_summary got nbits=%0d align=%0d end=%0d want 12 1 1",
               got.size(), na, ne);
    end
  endtask

  task automatic test_violation();
    int q[$];
    logic [6:0] o, i, e;
    int nv, ne, ns;
    nv = 0; ne = 0; ns = 0;
    push_sync(q);
    q = {q, 1,1,1,1,1,1, SE0, 0};
    foreach (q[k]) begin
      e = m_step(q[k], 0);
      send(q[k], 0, 1, o, i);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL violation step %0d got %b want %b", k, o, e);
      end
      nv += int'(o[1]); ne += int'(o[3]); ns += int'(o[5]);
    end
    n_checks++;
    if (nv != 5 || ne != 0 || ns == 0 || o[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL violation_summary got nv=%0d ne=%0d stuff_cycles=%0d final=%b want 5 0 >0 0",
               nv, ne, ns, o[5]);
    end
    test_basic(3);
  endtask

  task automatic test_abort();
    int q[$];
    logic [6:0] o, i, e;
    push_sync(q);
    q = {q, 1, 0, 1};
    foreach (q[k]) begin
      e = m_step(q[k], 0);
      send(q[k], 0, 2, o, i);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL abort_pre step %0d got %b want %b", k, o, e);
      end
    end
    e = m_step(1, 1);
    send(1, 1, 2, o, i);
    n_checks++;
    if ({rx_active, stuff_error, align_error, end_decode, start_decode,
         s_valid, s_out} !== 7'd0 || o !== e) begin
      n_fail++;
      $display("FAIL abort got %b want 0", o);
    end
    test_basic(3);
  endtask

  task automatic test_noise();
    int q[$];
    logic [6:0] o, i, e;
    int bad, rxs;
    bad = 0; rxs = 0;
    q = '{0,0,0,0,0,0,0,0, SE0};
    push_sync(q);
    q.push_back(SE0);
    foreach (q[k]) begin
      e = m_step(q[k], 0);
      send(q[k], 0, 2, o, i);
      n_checks++;
      if (o !== e) begin
        n_fail++;
        $display("FAIL noise step %0d got %b want %b", k, o, e);
      end
      bad += int'(o[1] | o[2] | o[3]);
      rxs += int'(o[6]);
    end
    n_checks++;
    if (bad != 0 || rxs != 1 || o[6] !== 1'b0) begin
      n_fail++;
      $display("FAIL noise_summary got bad=%0d rx_cycles=%0d rx=%b want 0 1 0",
               bad, rxs, o[6]);
    end
  endtask

  task automatic test_saturation();
    int q[$];
    logic [6:0] o, i, e;
    int ne, na;
    ne = 0; na = 0;
    push_sync(q);
    for (int k = 0; k < 2048; k++) q.push_back(0);
    q.push_back(SE0); q.push_back(0);
    foreach (q[k]) begin
      e = m_step(q[k], 0);
      send(q[k], 0, 0, o, i);
      if (e != o) begin
        n_checks++;
        n_fail++;
        $display("FAIL saturation step %0d got %b want %b", k, o, e);
      end
      ne += int'(o[3]); na += int'(o[4]);
    end
    n_checks++;
    if (ne != 1 || na != 1) begin
      n_fail++;
      $display("FAIL saturation_summary got end=%0d align=%0d want 1 1", ne, na);
    end
  endtask

  task automatic test_random();
    logic [6:0] o, i, e;
    for (int p = 0; p < 40; p++) begin
      int q[$];
      int len;
      len = int'($urandom_range(0, 4));
      for (int k = 0; k < len; k++) q.push_back(int'($urandom_range(0, 1)));
      push_sync(q);
      len = int'($urandom_range(0, 30));
      for (int k = 0; k < len; k++)
        q.push_back(($urandom_range(0, 3) != 0) ? 1 : 0);
      q.push_back(SE0);
      if ($urandom_range(0, 1) != 0) q.push_back(SE0);
      q.push_back(0);
      foreach (q[k]) begin
        bit ab;
        int gap;
        ab = ($urandom_range(0, 63) == 0);
        gap = int'($urandom_range(0, 3));
        e = m_step(q[k], ab);
        send(q[k], ab, gap, o, i);
        n_checks++;
        if (o !== e) begin
          n_fail++;
          $display("FAIL random pkt %0d step %0d got %b want %b", p, k, o, e);
        end
        if (gap > 0) begin
          n_checks++;
          if (i !== {e[6:5], 5'd0}) begin
            n_fail++;
            $display("FAIL random_idle pkt %0d step %0d got %b want %b",
                     p, k, i, {e[6:5], 5'd0});
          end
        end
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_basic(3);
    test_stuff();
    test_violation();
    test_abort();
    test_noise();
    test_basic(0);
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
